// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone block-RAM responder.
package wb_bram_pkg;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 7;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SEL_W       = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured when IDLE accepts a transfer
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/wb_bram_mem.sv
// Single-port word array with per-byte write enables and asynchronous read.
module wb_bram_mem
  import wb_bram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (sel[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/wb_bram_resp.sv
// Wishbone slave over a byte-enable RAM with fixed request-to-ack latency.
// Define WB_BRAM_RESP_ERR_EN to answer out-of-window addresses with wbs_err_o.
module wb_bram_resp
  import wb_bram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h3800_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [SEL_W-1:0]  wbs_sel_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic [DATA_W-1:0] wbs_dat_o
);

  localparam int unsigned   LAT      = clamp_latency(LATENCY);
  localparam int unsigned   TAG_LSB  = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  wb_req_t                 req_q;
  logic                    bad_q;

  logic                    valid_c;
  logic                    idle_c;
  logic                    tag_miss_c;
  logic                    bad_c;
  logic                    enter_resp_c;
  logic                    mem_we_c;
  logic [DEPTH_LOG2-1:0]   idx_c;
  wb_req_t                 req_c;
  logic [DATA_W-1:0]       rdata_c;
  logic                    unused_c;

`ifdef WB_BRAM_RESP_ERR_EN
  assign tag_miss_c = (wbs_adr_i[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]);
`else
  assign tag_miss_c = 1'b0;
`endif

  assign unused_c = ^{wbs_adr_i[1:0], wbs_adr_i[31:TAG_LSB], BASE_ADDR};

  // Live bus fields while IDLE (LATENCY=1 responds off them), latched copy afterwards
  always_comb begin
    valid_c = wbs_cyc_i & wbs_stb_i;
    idle_c  = (state == IDLE);
    idx_c   = idx_q;
    req_c   = req_q;
    bad_c   = bad_q;
    if (idle_c) begin
      idx_c = wbs_adr_i[TAG_LSB-1:2];
      req_c = '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
      bad_c = tag_miss_c;
    end
    enter_resp_c = valid_c & ((idle_c & (LAT == 1)) |
                              ((state == WAIT) & (cnt == CNT_W'(1))));
    mem_we_c = enter_resp_c & req_c.we & ~bad_c;
  end

  wb_bram_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (mem_we_c),
    .sel   (req_c.sel),
    .idx   (idx_c),
    .wdata (req_c.dat),
    .rdata (rdata_c)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      req_q     <= '0;
      bad_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= enter_resp_c & ~bad_c;
      wbs_dat_o <= (enter_resp_c & ~req_c.we & ~bad_c) ? rdata_c : '0;
      case (state)
        IDLE: begin
          if (valid_c) begin
            idx_q <= idx_c;
            req_q <= req_c;
            bad_q <= bad_c;
            cnt   <= CNT_LOAD;
            state <= (LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // Dropping the request while waiting abandons the transfer silently
          if (!valid_c) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (enter_resp_c) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_BRAM_RESP_ERR_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wbs_err_o <= 1'b0;
    else          wbs_err_o <= enter_resp_c & bad_c;
  end
`else
  assign wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bram_resp.sv
// Directed self-checking bench for wb_bram_resp at latencies 1, 3 and 4.
module tb_wb_bram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc1, cyc3, cyc4, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack1, ack3, ack4, err1, err3, err4;
  logic [31:0] do1, do3, do4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_bram_resp #(.LATENCY(1)) u_lat1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc1),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack1), .wbs_err_o(err1), .wbs_dat_o(do1));

  wb_bram_resp u_lat3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc3),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack3), .wbs_err_o(err3), .wbs_dat_o(do3));

  wb_bram_resp #(.LATENCY(4)) u_lat4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc4),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack4), .wbs_err_o(err4), .wbs_dat_o(do4));

  function automatic logic ack_of(input int lat);
    case (lat)
      1: return ack1;
      3: return ack3;
      4: return ack4;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic err_of(input int lat);
    case (lat)
      1: return err1;
      3: return err3;
      4: return err4;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] dat_of(input int lat);
    case (lat)
      1: return do1;
      3: return do3;
      4: return do4;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_cyc(input int lat, input logic v);
    case (lat)
      1: cyc1 = v;
      3: cyc3 = v;
      4: cyc4 = v;
      default: ;
    endcase
  endtask

  // One transfer: request issued in cycle 0, held until the first response, 10 cycles observed
  task automatic xfer(input int lat, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output int ack_cyc, output int err_cyc, output int n_resp,
                      output logic [31:0] rd);
    @(negedge clk);
    set_cyc(lat, 1'b1);
    stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    ack_cyc = -1; err_cyc = -1; n_resp = 0; rd = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ack_of(lat)) begin
        if (ack_cyc < 0) begin ack_cyc = k; rd = dat_of(lat); end
        n_resp++;
      end
      if (err_of(lat)) begin
        if (err_cyc < 0) begin err_cyc = k; rd = dat_of(lat); end
        n_resp++;
      end
      if (n_resp != 0) begin
        set_cyc(lat, 1'b0);
        stb = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ack1, ack3, ack4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ack: got %b, expected 000", {ack1, ack3, ack4});
    end
    n_checks++;
    if ({err1, err3, err4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err: got %b, expected 000", {err1, err3, err4});
    end
    n_checks++;
    if (do3 !== 32'h0) begin
      n_fail++; $display("FAIL reset_dat3: got %h, expected 0", do3);
    end
    n_checks++;
    if (do1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_dat1: got %h, expected 0", do1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int a, e, n;
    logic [31:0] rd;
    xfer(3, 1'b1, 32'h3800_0010, 4'hF, 32'hDEADBEEF, a, e, n, rd);
    n_checks++;
    if (a !== 3 || n !== 1) begin
      n_fail++; $display("FAIL wr_ack_cycle: got cycle %0d count %0d, expected cycle 3 count 1", a, n);
    end
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL wr_dat_zero: got %h, expected 0", rd);
    end
    xfer(3, 1'b0, 32'h3800_0010, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (a !== 3 || n !== 1) begin
      n_fail++; $display("FAIL rd_ack_cycle: got cycle %0d count %0d, expected cycle 3 count 1", a, n);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data: got %h, expected deadbeef", rd);
    end
    n_checks++;
    if (do3 !== 32'h0) begin
      n_fail++; $display("FAIL rd_dat_idle: got %h, expected 0", do3);
    end
  endtask

  task automatic test_byte_enable;
    int a, e, n;
    logic [31:0] rd;
    xfer(3, 1'b1, 32'h3800_0020, 4'hF, 32'hAABBCCDD, a, e, n, rd);
    xfer(3, 1'b1, 32'h3800_0020, 4'b0101, 32'h11223344, a, e, n, rd);
    xfer(3, 1'b0, 32'h3800_0020, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (rd !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL byte_merge: got %h, expected aa22cc44", rd);
    end
    xfer(3, 1'b1, 32'h3800_0020, 4'b0000, 32'h0, a, e, n, rd);
    n_checks++;
    if (a !== 3) begin
      n_fail++; $display("FAIL sel0_ack: got cycle %0d, expected 3", a);
    end
    xfer(3, 1'b0, 32'h3800_0023, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (rd !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL sel0_nochange_lowbits: got %h, expected aa22cc44", rd);
    end
  endtask

  task automatic test_abort;
    int early, first, cnt;
    logic [31:0] rd;
    int a, e, n;
    // Read dropped in cycle 1, new read raised in cycle 3
    @(negedge clk);
    cyc3 = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3800_0010; sel = 4'hF;
    early = 0;
    @(negedge clk); stb = 1'b0; if (ack3) early++;
    @(negedge clk); if (ack3) early++;
    @(negedge clk); stb = 1'b1; if (ack3) early++;
    first = -1; cnt = 0; rd = 32'h0;
    for (int k = 4; k <= 10; k++) begin
      @(negedge clk);
      if (ack3) begin
        if (first < 0) begin first = k; rd = do3; end
        cnt++;
        cyc3 = 1'b0; stb = 1'b0;
      end
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++; $display("FAIL abort_no_ack: got %0d acks, expected 0", early);
    end
    n_checks++;
    if (first !== 6 || cnt !== 1) begin
      n_fail++; $display("FAIL abort_retry_cycle: got cycle %0d count %0d, expected cycle 6 count 1", first, cnt);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL abort_retry_data: got %h, expected deadbeef", rd);
    end
    // Write dropped in its last wait cycle must not reach memory
    @(negedge clk);
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0010; sel = 4'hF; dat = 32'h0;
    @(negedge clk);
    @(negedge clk); stb = 1'b0; cyc3 = 1'b0;
    cnt = 0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      if (ack3 || err3) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL abort_wr_no_resp: got %0d responses, expected 0", cnt);
    end
    xfer(3, 1'b0, 32'h3800_0010, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL abort_wr_no_write: got %h, expected deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid;
    int a, e, n, cnt;
    logic [31:0] rd;
    xfer(4, 1'b1, 32'h3800_0040, 4'hF, 32'h12345678, a, e, n, rd);
    n_checks++;
    if (a !== 4) begin
      n_fail++; $display("FAIL lat4_ack_cycle: got %0d, expected 4", a);
    end
    @(negedge clk);
    cyc4 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0040; sel = 4'hF; dat = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    #1 if (ack4) cnt++;
    @(negedge clk); rst = 1'b0; cyc4 = 1'b0; stb = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack4) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_ack: got %0d acks, expected 0", cnt);
    end
    xfer(4, 1'b0, 32'h3800_0040, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (rd !== 32'h12345678) begin
      n_fail++; $display("FAIL rst_mid_no_write: got %h, expected 12345678", rd);
    end
  endtask

  task automatic test_alias_err;
    int a, e, n;
    logic [31:0] rd;
    logic [31:0] exp_word;
    xfer(3, 1'b1, 32'h3800_0000, 4'hF, 32'hCAFEF00D, a, e, n, rd);
    xfer(3, 1'b1, 32'h3800_0004, 4'hF, 32'h00000077, a, e, n, rd);
    xfer(3, 1'b0, 32'h3900_0000, 4'hF, 32'h0, a, e, n, rd);
`ifdef WB_BRAM_RESP_ERR_EN
    n_checks++;
    if (e !== 3 || a !== -1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oow_read_err: got err %0d ack %0d dat %h, expected err 3 ack -1 dat 0", e, a, rd);
    end
    exp_word = 32'h00000077;
`else
    n_checks++;
    if (a !== 3 || e !== -1 || rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL alias_read: got ack %0d err %0d dat %h, expected ack 3 err -1 dat cafef00d", a, e, rd);
    end
    exp_word = 32'h00000005;
`endif
    xfer(3, 1'b1, 32'h3900_0004, 4'hF, 32'h00000005, a, e, n, rd);
    n_checks++;
    if (n !== 1) begin
      n_fail++; $display("FAIL oow_write_resp: got %0d responses, expected 1", n);
    end
    xfer(3, 1'b0, 32'h3800_0004, 4'hF, 32'h0, a, e, n, rd);
    n_checks++;
    if (rd !== exp_word) begin
      n_fail++; $display("FAIL oow_write_effect: got %h, expected %h", rd, exp_word);
    end
  endtask

  task automatic test_back_to_back;
    int a, e, n, bad;
    logic [31:0] rd;
    logic [6:0]  pat;
    xfer(1, 1'b1, 32'h3800_0008, 4'hF, 32'h0BADF00D, a, e, n, rd);
    n_checks++;
    if (a !== 1) begin
      n_fail++; $display("FAIL lat1_ack_cycle: got %0d, expected 1", a);
    end
    @(negedge clk);
    cyc1 = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3800_0008; sel = 4'hF;
    pat = 7'b0; bad = 0;
    pat[0] = ack1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pat[k] = ack1;
      if (ack1 && do1 !== 32'h0BADF00D) bad++;
      if (!ack1 && do1 !== 32'h0) bad++;
    end
    cyc1 = 1'b0; stb = 1'b0;
    n_checks++;
    if (pat !== 7'b0101010) begin
      n_fail++; $display("FAIL b2b_ack_pattern: got %b, expected 0101010", pat);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL b2b_data: got %0d bad data cycles, expected 0", bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    cyc1 = 1'b0; cyc3 = 1'b0; cyc4 = 1'b0;
    stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
    test_reset;
    test_write_read;
    test_byte_enable;
    test_abort;
    test_reset_mid;
    test_alias_err;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bram_resp.md
WB_BRAM_RESP -- requirements
Module: wb_bram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 3, legal range 1..7, meaning the request-to-ack distance in clock cycles.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3800_0000, meaning the byte base of the decoded window, aligned to 4*2^DEPTH_LOG2.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: clock, all state on rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_stb_i and wbs_cyc_i, input, 1 bit each: Wishbone strobe and cycle from the arbiter.
REQ-007 SHALL have port wbs_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port wbs_sel_i, input, 4 bits: byte enables, bit n enables bits [8n+7:8n].
REQ-009 SHALL have ports wbs_dat_i and wbs_adr_i, input, 32 bits each: write data and byte address.
REQ-010 SHALL have port wbs_ack_o, output, 1 bit: single-cycle transfer acknowledge, registered.
REQ-011 SHALL have port wbs_err_o, output, 1 bit: single-cycle error acknowledge, registered.
REQ-012 SHALL have port wbs_dat_o, output, 32 bits: read data.

Function
REQ-013 SHALL treat a request as valid when wbs_cyc_i and wbs_stb_i are both 1.
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE->WAIT on valid request; WAIT->RESP when the latency counter expires; RESP->IDLE unconditionally.
REQ-015 SHALL latch adr, we, sel and dat in the cycle IDLE samples the request (cycle 0) and ignore later changes to them.
REQ-016 SHALL load the 3-bit counter with LATENCY-1 at cycle 0; with LATENCY=1, SHALL bypass WAIT and go IDLE->RESP directly.
REQ-017 SHALL hold wbs_ack_o (or wbs_err_o) high for exactly the one cycle spent in RESP, which is cycle LATENCY.
REQ-018 SHALL take the word index from adr[DEPTH_LOG2+1:2] and ignore adr[1:0].
REQ-019 SHALL perform writes on the clock edge that enters RESP, updating only sel-enabled bytes; sel=4'b0000 SHALL ack with no memory change.
REQ-020 SHALL drive wbs_dat_o with the addressed word during the RESP cycle of a read, and with 32'h0 in every other cycle.
REQ-021 SHALL return to IDLE with no ack, no err and no write if valid drops while in WAIT (abort).
REQ-022 SHALL ignore a request that is still high during RESP; it is sampled again in the following IDLE cycle, giving back-to-back throughput of LATENCY+1 cycles per transfer.
REQ-023 SHALL never assert wbs_ack_o and wbs_err_o in the same cycle.

Reset
REQ-024 SHALL, on wb_rst_i, force state IDLE, counter 0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0 immediately, with no clock required.
REQ-025 SHALL discard any pending write when reset asserts mid-transfer.
REQ-026 SHALL not reset memory contents.

Configuration
REQ-027 SHALL use macro WB_BRAM_RESP_ERR_EN.
REQ-028 With WB_BRAM_RESP_ERR_EN defined, a request whose adr[31:DEPTH_LOG2+2] differs from BASE_ADDR SHALL respond with wbs_err_o in cycle LATENCY instead of ack, with no write and wbs_dat_o=0.
REQ-029 Without WB_BRAM_RESP_ERR_EN, upper address bits SHALL be ignored (aliasing) and wbs_err_o SHALL be tied to 0.

Structure
REQ-030 SHALL place the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the LATENCY_MIN=1 and LATENCY_MAX=7 constants in the shared package wb_bram_pkg.
REQ-031 SHALL place the byte-enable single-port array in sub-module wb_bram_mem (clk, we, sel, idx, wdata, rdata).

Verification
REQ-032 Write 32'hDEADBEEF to 0x3800_0010 with sel=4'hF and LATENCY=3 -> ack high only in cycle 3; a following read returns 32'hDEADBEEF in its ack cycle.
REQ-033 Write 32'h11223344 with sel=4'b0101 over a word holding 32'hAABBCCDD -> read returns 32'hAA22CC44.
REQ-034 Assert a read, drop stb in cycle 1 with LATENCY=3 -> no ack, state IDLE by cycle 2; a new request in cycle 3 acks in cycle 6.
REQ-035 Pulse wb_rst_i in cycle 2 of a write with LATENCY=4 -> ack never asserts and the target word is unchanged.
REQ-036 With the macro defined, read 0x3900_0000 -> err high in cycle LATENCY and ack 0; without the macro -> ack, data from word index 0.
REQ-037 Hold stb high for back-to-back reads with LATENCY=1 -> acks in cycles 1, 3, 5.
